prod_accumulator: RTL and testbench
===================================

PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter ACC_W, default 24, accumulator and out_sum width; legal range 16..32.
REQ-002 Parameter CNT_W, default 8, beat-counter and out_count width; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_prod/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_prod  input  16  unsigned product word from upstream 8x8 multiplier (y).
REQ-008 in_last  input  1  marks final beat of a frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_sum  output  ACC_W  accumulated sum of frame products.
REQ-012 out_count  output  CNT_W  number of beats in the frame.
REQ-013 out_ovf  output  1  sticky: an addition in this frame exceeded ACC_W bits.

Function
REQ-014 Beat accepted iff in_valid && in_ready at a rising edge; result taken iff out_valid && out_ready.
REQ-015 FSM states IDLE, ACC, HOLD; reset state IDLE.
REQ-016 in_ready = 1 in IDLE and ACC, 0 in HOLD; out_valid = 1 only in HOLD, both decoded from registered state.
REQ-017 IDLE + accepted beat: acc <- zero-extended in_prod, cnt <- 1, ovf <- 0; next HOLD if in_last, else ACC.
REQ-018 ACC + accepted beat: acc <- acc + in_prod (ACC_W+1-bit add), cnt <- cnt+1, ovf <- ovf | carry-out; next HOLD if in_last or new cnt = 2^CNT_W-1, else ACC.
REQ-019 Count limit: a frame reaching 2^CNT_W-1 beats closes as if in_last were set; following beats start a new frame.
REQ-020 No accepted beat in IDLE/ACC: all state held; idle cycles inside a frame allowed.
REQ-021 HOLD: out_sum, out_count, out_ovf stable until taken; on take -> IDLE next cycle, acc/cnt/ovf cleared.
REQ-022 Latency: out_valid asserted the cycle after the last beat is accepted; minimum one bubble cycle between frames.
REQ-023 in_prod, in_last ignored whenever in_ready = 0.
REQ-024 out_sum/out_count/out_ovf read 0 in IDLE and hold running values in ACC (not qualified by out_valid there).

Reset
REQ-025 rst asserted at a rising edge: state IDLE, acc 0, cnt 0, ovf 0; outputs in_ready 1 (from the following cycle), out_valid 0, out_sum 0, out_count 0, out_ovf 0.
REQ-026 rst dominates any same-cycle accept or take; a partial frame or unconsumed result is discarded.

Configuration
REQ-027 Macro PACC_SATURATE_EN defined: on carry-out acc <- all ones (2^ACC_W-1) and stays there for the rest of the frame; out_ovf set.
REQ-028 PACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W; out_ovf still set sticky.

Verification
REQ-029 Single beat 0xFE01 with in_last -> next cycle out_valid=1, out_sum=0x00FE01, out_count=1, out_ovf=0.
REQ-030 Beats 0x0001,0x0002,0x0003(last) with idle gaps -> out_sum=6, out_count=3; in_ready=0 while out_ready held 0 for 5 cycles, outputs stable.
REQ-031 ACC_W=17, three beats 0xFE01 -> out_ovf=1; out_sum=0x0FA03 without macro, 0x1FFFF with PACC_SATURATE_EN.
REQ-032 CNT_W=2, five beats of 0x0010, in_last never set -> frame 1 out_sum=0x30, count 3; frame 2 open with count 2, no result until in_last.
REQ-033 rst pulsed after 2 beats of a frame -> out_valid 0, in_ready 1; next frame 0x0005(last) -> out_sum=5, out_count=1.
REQ-034 out_valid and out_ready held 1 with back-to-back single-beat frames -> one result per two cycles, no beat lost or duplicated.

Source files
------------

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums a frame of 16-bit products into an ACC_W-bit total with beat count and sticky overflow.
// Define PACC_SATURATE_EN to clamp the sum at all ones on overflow instead of wrapping.
module prod_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             take;
  logic             close;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, in_prod};
  assign cnt_next = cnt + CNT_W'(1);

  // A frame that fills the counter closes exactly as if in_last had been seen.
  assign close = in_last || (cnt_next == {CNT_W{1'b1}});

`ifdef PACC_SATURATE_EN
  assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(in_prod);
            cnt   <= CNT_W'(1);
            ovf   <= 1'b0;
            state <= in_last ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf | sum_ext[ACC_W];
            state <= close ? HOLD : ACC;
          end
        end
        HOLD: begin
          // Result stays frozen until taken; clearing here makes IDLE read as zero.
          if (take) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator: drives a default-sized and a narrow (ACC_W=17, CNT_W=2) accumulator from one input bus
// and checks both every cycle against a frame-level arithmetic model; honours PACC_SATURATE_EN.
module tb_prod_accumulator;

  localparam int M_ACC_W = 24;
  localparam int M_CNT_W = 8;
  localparam int S_ACC_W = 17;
  localparam int S_CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = 16'h0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic               m_in_ready, m_out_valid, m_out_ovf;
  logic [M_ACC_W-1:0] m_out_sum;
  logic [M_CNT_W-1:0] m_out_count;
  logic               s_in_ready, s_out_valid, s_out_ovf;
  logic [S_ACC_W-1:0] s_out_sum;
  logic [S_CNT_W-1:0] s_out_count;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Frame-level view: true (unbounded) total and beat count, plus whether a result is waiting.
  typedef struct {
    bit              pending;
    longint unsigned total;
    int              beats;
  } model_t;

  model_t m_ref = '{1'b0, 64'd0, 0};
  model_t s_ref = '{1'b0, 64'd0, 0};

  prod_accumulator #(.ACC_W(M_ACC_W), .CNT_W(M_CNT_W)) dut_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(m_out_valid), .out_ready(out_ready), .out_sum(m_out_sum),
    .out_count(m_out_count), .out_ovf(m_out_ovf)
  );

  prod_accumulator #(.ACC_W(S_ACC_W), .CNT_W(S_CNT_W)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_prod(in_prod),
    .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  always #5 clk = ~clk;

  function automatic model_t model_step(model_t cur, int cnt_w);
    model_t nxt;
    int     limit;
    nxt   = cur;
    limit = (1 << cnt_w) - 1;
    if (rst) begin
      nxt = '{1'b0, 64'd0, 0};
    end else if (cur.pending) begin
      if (out_ready) nxt = '{1'b0, 64'd0, 0};
    end else if (in_valid) begin
      nxt.total = cur.total + 64'(in_prod);
      nxt.beats = cur.beats + 1;
      if (in_last || nxt.beats == limit) nxt.pending = 1'b1;
    end
    return nxt;
  endfunction

  function automatic logic [63:0] exp_sum(model_t m, int acc_w);
    longint unsigned lim;
    lim = 64'd1 << acc_w;
    if (m.total >= lim) begin
`ifdef PACC_SATURATE_EN
      return lim - 64'd1;
`else
      return m.total % lim;
`endif
    end
    return m.total;
  endfunction

  function automatic logic [63:0] exp_ovf(model_t m, int acc_w);
    return (m.total >= (64'd1 << acc_w)) ? 64'd1 : 64'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model advances on the same edge the DUTs do, seeing the same pre-edge inputs.
  always @(posedge clk) begin
    m_ref <= model_step(m_ref, M_CNT_W);
    s_ref <= model_step(s_ref, S_CNT_W);
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("main.in_ready",  64'(m_in_ready),  64'(!m_ref.pending));
      checkOutput("main.out_valid", 64'(m_out_valid), 64'(m_ref.pending));
      checkOutput("main.out_sum",   64'(m_out_sum),   exp_sum(m_ref, M_ACC_W));
      checkOutput("main.out_count", 64'(m_out_count), 64'(m_ref.beats));
      checkOutput("main.out_ovf",   64'(m_out_ovf),   exp_ovf(m_ref, M_ACC_W));
      checkOutput("small.in_ready",  64'(s_in_ready),  64'(!s_ref.pending));
      checkOutput("small.out_valid", 64'(s_out_valid), 64'(s_ref.pending));
      checkOutput("small.out_sum",   64'(s_out_sum),   exp_sum(s_ref, S_ACC_W));
      checkOutput("small.out_count", 64'(s_out_count), 64'(s_ref.beats));
      checkOutput("small.out_ovf",   64'(s_out_ovf),   exp_ovf(s_ref, S_ACC_W));
    end
  end

  task automatic applyStimulus(input bit v, input logic [15:0] p, input bit l, input bit r);
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1);
  endtask

  initial begin
    int accepted;
    bit ready_before;

    // Reset state
    pulseReset();
    model_on = 1'b1;
    checkOutput("rst_out_valid", 64'(m_out_valid), 64'd0);
    checkOutput("rst_in_ready",  64'(m_in_ready),  64'd1);
    checkOutput("rst_out_sum",   64'(m_out_sum),   64'd0);
    checkOutput("rst_out_count", 64'(m_out_count), 64'd0);
    checkOutput("rst_out_ovf",   64'(m_out_ovf),   64'd0);

    // Single-beat frame
    applyStimulus(1'b1, 16'hFE01, 1'b1, 1'b0);
    checkOutput("single_valid", 64'(m_out_valid), 64'd1);
    checkOutput("single_sum",   64'(m_out_sum),   64'h00FE01);
    checkOutput("single_count", 64'(m_out_count), 64'd1);
    checkOutput("single_ovf",   64'(m_out_ovf),   64'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("taken_valid", 64'(m_out_valid), 64'd0);
    checkOutput("taken_sum",   64'(m_out_sum),   64'd0);

    // Gapped frame, then downstream stall with junk offered upstream
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
    checkOutput("gap_sum",   64'(m_out_sum),   64'd6);
    checkOutput("gap_count", 64'(m_out_count), 64'd3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
      checkOutput("stall_in_ready", 64'(m_in_ready), 64'd0);
      checkOutput("stall_sum",      64'(m_out_sum),  64'd6);
      checkOutput("stall_count",    64'(m_out_count), 64'd3);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Overflow on the narrow instance
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'hFE01, 1'b0, 1'b0);
    checkOutput("ovf_valid", 64'(s_out_valid), 64'd1);
    checkOutput("ovf_flag",  64'(s_out_ovf),   64'd1);
    checkOutput("ovf_count", 64'(s_out_count), 64'd3);
`ifdef PACC_SATURATE_EN
    checkOutput("ovf_sum",   64'(s_out_sum),   64'h1FFFF);
`else
    checkOutput("ovf_sum",   64'(s_out_sum),   64'h0FA03);
`endif
    checkOutput("running_sum",   64'(m_out_sum),   64'h2FA03);
    checkOutput("running_valid", 64'(m_out_valid), 64'd0);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    checkOutput("close_count", 64'(m_out_count), 64'd4);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Count-limit closure on the narrow instance, with proper handshaking
    accepted = 0;
    for (int i = 0; i < 20 && accepted < 5; i++) begin
      ready_before = s_in_ready;
      applyStimulus(1'b1, 16'h0010, 1'b0, 1'b1);
      if (ready_before) begin
        accepted++;
        if (accepted == 3) begin
          checkOutput("limit_valid", 64'(s_out_valid), 64'd1);
          checkOutput("limit_sum",   64'(s_out_sum),   64'h30);
          checkOutput("limit_count", 64'(s_out_count), 64'd3);
        end
      end
    end
    checkOutput("limit_accepted", 64'(accepted),      64'd5);
    checkOutput("frame2_valid",   64'(s_out_valid),   64'd0);
    checkOutput("frame2_count",   64'(s_out_count),   64'd2);
    checkOutput("frame2_sum",     64'(s_out_sum),     64'h20);

    // Reset discards a partial frame
    applyStimulus(1'b1, 16'h0007, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0);
    pulseReset();
    checkOutput("abort_valid", 64'(m_out_valid), 64'd0);
    checkOutput("abort_ready", 64'(m_in_ready),  64'd1);
    checkOutput("abort_count", 64'(m_out_count), 64'd0);
    applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0);
    checkOutput("after_rst_sum",   64'(m_out_sum),   64'd5);
    checkOutput("after_rst_count", 64'(m_out_count), 64'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Back-to-back single-beat frames with downstream always ready
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 1'b1, 1'b1);
      checkOutput("b2b_valid", 64'(m_out_valid), 64'((i % 2) == 0));
      if ((i % 2) == 0) checkOutput("b2b_sum", 64'(m_out_sum), 64'(i + 1));
    end

    // Randomized traffic; the every-cycle model comparison does the checking
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) ? (16'hFF00 | 16'($urandom_range(0, 255))) : 16'($urandom),
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
